// File: rtl/spi_minion_fifo_adapter_if.sv
// Message-side handshake bundle of the SPI minion FIFO adapter.
// master: the adapter (drives out_msg/out_val and in_rdy); slave: the user design.
`timescale 1ns/1ps
interface spi_minion_fifo_adapter_if #(
    parameter int unsigned NBITS = 32
);
    logic [NBITS-1:0] out_msg;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] in_msg;
    logic             in_val;
    logic             in_rdy;

    modport master (
        output out_msg,
        output out_val,
        input  out_rdy,
        input  in_msg,
        input  in_val,
        output in_rdy
    );

    modport slave (
        input  out_msg,
        input  out_val,
        output out_rdy,
        output in_msg,
        output in_val,
        input  in_rdy
    );
endinterface

// File: rtl/spi_minion_fifo_adapter.sv
// SPI minion (mode 0) with credit flow control and RX/TX message FIFOs.
// All SPI pins are oversampled in the clk domain; packet = {val, space, payload}.
`timescale 1ns/1ps
module spi_minion_fifo_adapter #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_cs,
    input  logic                         spi_sclk,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic                         loopthrough_sel,
    spi_minion_fifo_adapter_if.master    msg,
    output logic [$clog2(DEPTH+1)-1:0]   rx_count,
    output logic [$clog2(DEPTH+1)-1:0]   tx_count,
    output logic                         parity
);
    localparam int unsigned P  = NBITS + 2;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(P + 2);
    localparam logic [BW-1:0] CNT_FULL  = BW'(P);
    localparam logic [BW-1:0] CNT_SAT   = BW'(P + 1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    typedef enum logic {IDLE, XFER} state_t;

    // synchronizers and edge detection
    logic       cs_s1, cs_s2, cs_s3;
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       mosi_s1, mosi_s2;
    logic [1:0] sync_vld;
    logic       cs_armed;
    logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

    // transaction state
    state_t          state;
    logic [P-1:0]    shreg;
    logic            sample;
    logic [BW-1:0]   bitcnt;
    logic            tx_val_l, rx_space_l;
    logic [P-1:0]    rx_pkt;
    logic            xfer_end, spi_push, spi_pop;

    // FIFOs
    logic [NBITS-1:0] rx_mem [DEPTH];
    logic [NBITS-1:0] tx_mem [DEPTH];
    logic [AW-1:0]    rx_wr, rx_rd, tx_wr, tx_rd;
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_push, rx_pop, tx_push, tx_pop, loop_move;
    logic [NBITS-1:0] tx_head, tx_din;

    // Two-flop synchronizers plus an edge-detect flop on cs/sclk. cs_armed keeps a
    // transaction that was already in progress when reset released from being seen:
    // it is only set once a genuine (post-reset) high level of cs has been sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_s3    <= 1'b1;
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            sync_vld <= '0;
            cs_armed <= 1'b0;
        end else begin
            cs_s1    <= spi_cs;
            cs_s2    <= cs_s1;
            cs_s3    <= cs_s2;
            sclk_s1  <= spi_sclk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            mosi_s1  <= spi_mosi;
            mosi_s2  <= mosi_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && cs_s2) begin
                cs_armed <= 1'b1;
            end
        end
    end

    // Edge strobes, received packet and FIFO control decode.
    always_comb begin
        cs_fall   = cs_s3 & ~cs_s2;
        cs_rise   = ~cs_s3 & cs_s2;
        sclk_rise = ~sclk_s3 & sclk_s2;
        sclk_fall = sclk_s3 & ~sclk_s2;

        rx_pkt    = {shreg[P-2:0], sample};
        xfer_end  = (state == XFER) && cs_rise && (bitcnt == CNT_FULL);
        spi_push  = xfer_end && rx_pkt[P-1] && rx_space_l;
        spi_pop   = xfer_end && rx_pkt[P-2] && tx_val_l;

        rx_empty  = (rx_count == '0);
        rx_full   = (rx_count == CNT_DEPTH);
        tx_empty  = (tx_count == '0);
        tx_full   = (tx_count == CNT_DEPTH);
        tx_head   = tx_empty ? '0 : tx_mem[tx_rd];

        loop_move = loopthrough_sel && !rx_empty && !tx_full;
        rx_push   = spi_push;
        rx_pop    = loop_move || (!loopthrough_sel && !rx_empty && msg.out_rdy);
        tx_push   = loop_move || (!loopthrough_sel && !tx_full && msg.in_val);
        tx_pop    = spi_pop;
        tx_din    = loopthrough_sel ? rx_mem[rx_rd] : msg.in_msg;
    end

    assign msg.out_msg = rx_mem[rx_rd];
    assign msg.out_val = !rx_empty && !loopthrough_sel;
    assign msg.in_rdy  = !tx_full && !loopthrough_sel;
    assign spi_miso    = shreg[P-1];

    // Transaction FSM: load on cs fall, sample on sclk rise, shift on sclk fall.
    // The fall that follows the final (P-th) rise does not shift, so the last
    // P-1 samples stay in shreg[P-2:0] and the P-th stays in sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            sample     <= 1'b0;
            bitcnt     <= '0;
            tx_val_l   <= 1'b0;
            rx_space_l <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall && cs_armed) begin
                        state      <= XFER;
                        shreg      <= {!tx_empty, !rx_full, tx_head};
                        tx_val_l   <= !tx_empty;
                        rx_space_l <= !rx_full;
                        bitcnt     <= '0;
                    end
                end
                XFER: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end else begin
                        if (sclk_rise) begin
                            sample <= mosi_s2;
                            if (bitcnt != CNT_SAT) begin
                                bitcnt <= bitcnt + BW'(1);
                            end
                        end
                        if (sclk_fall && (bitcnt < CNT_FULL)) begin
                            shreg <= {shreg[P-2:0], sample};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancies and parity of the last RX push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            rx_count <= '0;
            tx_count <= '0;
            parity   <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) begin
                parity <= ^rx_pkt[NBITS-1:0];
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= rx_pkt[NBITS-1:0];
        if (tx_push) tx_mem[tx_wr] <= tx_din;
    end

endmodule

// File: tb/tb_spi_minion_fifo_adapter.sv
// Self-checking bench for spi_minion_fifo_adapter: SPI host driver, queue-based
// reference model of the RX/TX FIFOs and credit rules, directed and random tests.
`timescale 1ns/1ps
module tb_spi_minion_fifo_adapter;
    localparam int unsigned NBITS = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned P     = NBITS + 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spi_cs = 1'b1;
    logic          spi_sclk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          loopthrough_sel = 1'b0;
    logic [CW-1:0] rx_count, tx_count;
    logic          parity;

    spi_minion_fifo_adapter_if #(.NBITS(NBITS)) msg ();

    spi_minion_fifo_adapter #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_cs          (spi_cs),
        .spi_sclk        (spi_sclk),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .loopthrough_sel (loopthrough_sel),
        .msg             (msg.master),
        .rx_count        (rx_count),
        .tx_count        (tx_count),
        .parity          (parity)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [NBITS-1:0] rx_q[$];
    logic [NBITS-1:0] tx_q[$];
    logic             parity_m = 1'b0;
    logic [P-1:0]     miso_cap;

    function automatic logic [P-1:0] model_miso();
        logic [P-1:0] r;
        r = '0;
        r[P-1] = (tx_q.size() != 0);
        r[P-2] = (rx_q.size() < DEPTH);
        if (tx_q.size() != 0) r[NBITS-1:0] = tx_q[0];
        return r;
    endfunction

    // Apply a finished transaction of 'pulses' sclk pulses to the model.
    function automatic void model_xfer(input logic [P-1:0] pkt, input int pulses);
        bit rs, tv;
        rs = (rx_q.size() < DEPTH);
        tv = (tx_q.size() != 0);
        if (pulses == P) begin
            if (pkt[P-1] && rs) begin
                rx_q.push_back(pkt[NBITS-1:0]);
                parity_m = ^pkt[NBITS-1:0];
            end
            if (pkt[P-2] && tv) void'(tx_q.pop_front());
        end
    endfunction

    function automatic void model_loop();
        while (loopthrough_sel && rx_q.size() > 0 && tx_q.size() < DEPTH)
            tx_q.push_back(rx_q.pop_front());
    endfunction

    function automatic void model_clear();
        rx_q.delete();
        tx_q.delete();
        parity_m = 1'b0;
    endfunction

    // drivers (no checking)
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        spi_sclk = 1'b0;
        spi_cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic spi_bits(input logic [P-1:0] pkt, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            spi_mosi = pkt[P-1-i];
            wait_clk(3);
            miso_cap[P-1-i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(5);
            spi_sclk = 1'b0;
            wait_clk(3);
        end
    endtask

    task automatic spi_stop();
        wait_clk(3);
        spi_cs = 1'b1;
        wait_clk(10);
    endtask

    task automatic spi_xfer(input logic [P-1:0] pkt, input int n);
        spi_start();
        spi_bits(pkt, 0, n);
        spi_stop();
    endtask

    task automatic in_push(input logic [NBITS-1:0] d);
        msg.in_msg = d;
        msg.in_val = 1'b1;
        wait_clk(1);
        msg.in_val = 1'b0;
    endtask

    task automatic out_pop();
        msg.out_rdy = 1'b1;
        wait_clk(1);
        msg.out_rdy = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(3);
        checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", spi_miso); end
        checks++; if (msg.out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %b want 0", msg.out_val); end
        checks++; if (msg.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", msg.in_rdy); end
        checks++; if (rx_count !== '0) begin errors++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
        checks++; if (tx_count !== '0) begin errors++; $display("FAIL reset_tx_count got %0d want 0", tx_count); end
        checks++; if (parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", parity); end
        reset = 1'b1;
        model_clear();
        wait_clk(4);
    endtask

    task automatic test_rx_basic();
        logic [P-1:0] pkt;
        pkt = {2'b10, 32'hDEADBEEF};
        spi_start();
        spi_bits(pkt, 0, P);
        wait_clk(3);
        spi_cs = 1'b1;
        wait_clk(2);
        checks++; if (msg.out_val !== 1'b0) begin errors++; $display("FAIL rx_val_early got %b want 0", msg.out_val); end
        wait_clk(1);
        model_xfer(pkt, P);
        checks++; if (miso_cap[P-1 -: 2] !== 2'b01) begin errors++; $display("FAIL rx_miso_hdr got %b want 01", miso_cap[P-1 -: 2]); end
        checks++; if (msg.out_val !== 1'b1) begin errors++; $display("FAIL rx_val_3rd_edge got %b want 1", msg.out_val); end
        checks++; if (msg.out_msg !== 32'hDEADBEEF) begin errors++; $display("FAIL rx_msg got %h want deadbeef", msg.out_msg); end
        checks++; if (rx_count !== CW'(1)) begin errors++; $display("FAIL rx_count got %0d want 1", rx_count); end
        checks++; if (parity !== 1'b0) begin errors++; $display("FAIL rx_parity got %b want 0", parity); end
        wait_clk(8);
        out_pop();
        void'(rx_q.pop_front());
        checks++; if (msg.out_val !== 1'b0 || rx_count !== '0) begin errors++; $display("FAIL rx_drain got val %b cnt %0d want 0 0", msg.out_val, rx_count); end
    endtask

    task automatic test_tx_path();
        logic [P-1:0] pkt;
        logic [NBITS-1:0] w;
        w = 32'h12345678;
        checks++; if (msg.in_rdy !== 1'b1) begin errors++; $display("FAIL tx_in_rdy got %b want 1", msg.in_rdy); end
        in_push(w);
        tx_q.push_back(w);
        checks++; if (tx_count !== CW'(1)) begin errors++; $display("FAIL tx_count_enq got %0d want 1", tx_count); end
        pkt = {2'b01, NBITS'($urandom)};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        checks++; if (miso_cap !== {2'b11, w}) begin errors++; $display("FAIL tx_miso got %h want %h", miso_cap, {2'b11, w}); end
        checks++; if (tx_count !== '0) begin errors++; $display("FAIL tx_count_pop got %0d want 0", tx_count); end
        in_push(w);
        tx_q.push_back(w);
        pkt = {2'b00, NBITS'($urandom)};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        checks++; if (miso_cap !== {2'b11, w}) begin errors++; $display("FAIL tx_miso_nospace got %h want %h", miso_cap, {2'b11, w}); end
        checks++; if (tx_count !== CW'(1)) begin errors++; $display("FAIL tx_count_kept got %0d want 1", tx_count); end
        pkt = {2'b01, NBITS'($urandom)};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        checks++; if (miso_cap !== {2'b11, w}) begin errors++; $display("FAIL tx_miso_resend got %h want %h", miso_cap, {2'b11, w}); end
        checks++; if (tx_count !== '0) begin errors++; $display("FAIL tx_count_resend got %0d want 0", tx_count); end
    endtask

    task automatic test_rx_full();
        logic [P-1:0] pkt, exp;
        logic par_before;
        for (int i = 0; i < DEPTH; i++) begin
            pkt = {2'b10, NBITS'($urandom)};
            exp = model_miso();
            spi_xfer(pkt, P);
            model_xfer(pkt, P);
            checks++; if (miso_cap !== exp) begin errors++; $display("FAIL full_fill_miso%0d got %h want %h", i, miso_cap, exp); end
        end
        checks++; if (rx_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count got %0d want %0d", rx_count, DEPTH); end
        par_before = parity_m;
        pkt = {2'b10, NBITS'($urandom)};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        checks++; if (miso_cap[P-2] !== 1'b0) begin errors++; $display("FAIL full_space_bit got %b want 0", miso_cap[P-2]); end
        checks++; if (rx_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count_after got %0d want %0d", rx_count, DEPTH); end
        checks++; if (parity !== par_before) begin errors++; $display("FAIL full_parity got %b want %b", parity, par_before); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (msg.out_val !== 1'b1 || msg.out_msg !== rx_q[0]) begin errors++; $display("FAIL full_drain%0d got %b/%h want 1/%h", i, msg.out_val, msg.out_msg, rx_q[0]); end
            out_pop();
            void'(rx_q.pop_front());
        end
        checks++; if (rx_count !== '0) begin errors++; $display("FAIL full_drained got %0d want 0", rx_count); end
    endtask

    task automatic test_aborted();
        logic [P-1:0] pkt, exp;
        logic [NBITS-1:0] w;
        w = $urandom;
        in_push(w);
        tx_q.push_back(w);
        pkt = {2'b11, NBITS'($urandom)};
        spi_xfer(pkt, 20);
        model_xfer(pkt, 20);
        checks++; if (rx_count !== '0 || tx_count !== CW'(1)) begin errors++; $display("FAIL abort_counts got rx %0d tx %0d want 0 1", rx_count, tx_count); end
        checks++; if (msg.out_val !== 1'b0) begin errors++; $display("FAIL abort_out_val got %b want 0", msg.out_val); end
        pkt = {2'b11, NBITS'($urandom)};
        exp = model_miso();
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        checks++; if (miso_cap !== exp) begin errors++; $display("FAIL abort_next_miso got %h want %h", miso_cap, exp); end
        checks++; if (rx_count !== CW'(1) || tx_count !== '0) begin errors++; $display("FAIL abort_next_counts got rx %0d tx %0d want 1 0", rx_count, tx_count); end
        checks++; if (msg.out_msg !== pkt[NBITS-1:0]) begin errors++; $display("FAIL abort_next_msg got %h want %h", msg.out_msg, pkt[NBITS-1:0]); end
        out_pop();
        void'(rx_q.pop_front());
    endtask

    task automatic test_loopthrough();
        logic [P-1:0] pkt;
        loopthrough_sel = 1'b1;
        wait_clk(2);
        checks++; if (msg.out_val !== 1'b0 || msg.in_rdy !== 1'b0) begin errors++; $display("FAIL loop_ports got val %b rdy %b want 0 0", msg.out_val, msg.in_rdy); end
        in_push($urandom);
        checks++; if (tx_count !== '0) begin errors++; $display("FAIL loop_in_ignored got %0d want 0", tx_count); end
        pkt = {2'b10, 32'hA5A5A5A5};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        model_loop();
        checks++; if (msg.out_val !== 1'b0) begin errors++; $display("FAIL loop_out_val got %b want 0", msg.out_val); end
        checks++; if (rx_count !== '0 || tx_count !== CW'(1)) begin errors++; $display("FAIL loop_move got rx %0d tx %0d want 0 1", rx_count, tx_count); end
        pkt = {2'b01, NBITS'($urandom)};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        model_loop();
        checks++; if (miso_cap !== {2'b11, 32'hA5A5A5A5}) begin errors++; $display("FAIL loop_miso got %h want 3a5a5a5a5", miso_cap); end
        checks++; if (tx_count !== '0) begin errors++; $display("FAIL loop_tx_pop got %0d want 0", tx_count); end
        loopthrough_sel = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_reset_mid();
        logic [P-1:0] pkt;
        pkt = {2'b11, NBITS'($urandom)};
        spi_start();
        spi_bits(pkt, 0, 10);
        reset = 1'b0;
        wait_clk(2);
        checks++; if (spi_miso !== 1'b0 || rx_count !== '0 || tx_count !== '0) begin errors++; $display("FAIL midrst_state got miso %b rx %0d tx %0d want 0 0 0", spi_miso, rx_count, tx_count); end
        reset = 1'b1;
        model_clear();
        wait_clk(2);
        spi_bits(pkt, 10, P - 10);
        spi_stop();
        checks++; if (rx_count !== '0 || msg.out_val !== 1'b0) begin errors++; $display("FAIL midrst_ignored got rx %0d val %b want 0 0", rx_count, msg.out_val); end
        pkt = {2'b10, NBITS'($urandom)};
        spi_xfer(pkt, P);
        model_xfer(pkt, P);
        checks++; if (rx_count !== CW'(1) || msg.out_msg !== pkt[NBITS-1:0]) begin errors++; $display("FAIL midrst_next got rx %0d msg %h want 1 %h", rx_count, msg.out_msg, pkt[NBITS-1:0]); end
        checks++; if (parity !== parity_m) begin errors++; $display("FAIL midrst_parity got %b want %b", parity, parity_m); end
        out_pop();
        void'(rx_q.pop_front());
    endtask

    task automatic test_random();
        logic [P-1:0] pkt, exp;
        logic [NBITS-1:0] d;
        logic exp_b;
        int op, n;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 5));
            if (op == 0) begin
                d = $urandom;
                exp_b = (tx_q.size() < DEPTH);
                checks++; if (msg.in_rdy !== exp_b) begin errors++; $display("FAIL rand%0d_in_rdy got %b want %b", it, msg.in_rdy, exp_b); end
                in_push(d);
                if (exp_b) tx_q.push_back(d);
            end else if (op == 1) begin
                exp_b = (rx_q.size() != 0);
                checks++; if (msg.out_val !== exp_b) begin errors++; $display("FAIL rand%0d_out_val got %b want %b", it, msg.out_val, exp_b); end
                if (exp_b) begin
                    checks++; if (msg.out_msg !== rx_q[0]) begin errors++; $display("FAIL rand%0d_out_msg got %h want %h", it, msg.out_msg, rx_q[0]); end
                end
                out_pop();
                if (exp_b) void'(rx_q.pop_front());
            end else begin
                pkt[P-1] = 1'($urandom_range(0, 1));
                pkt[P-2] = 1'($urandom_range(0, 1));
                pkt[NBITS-1:0] = $urandom;
                n = (op == 5) ? int'($urandom_range(1, P - 1)) : int'(P);
                exp = model_miso();
                spi_xfer(pkt, n);
                model_xfer(pkt, n);
                if (n == P) begin
                    checks++; if (miso_cap !== exp) begin errors++; $display("FAIL rand%0d_miso got %h want %h", it, miso_cap, exp); end
                end
            end
            checks++; if (rx_count !== CW'(rx_q.size()) || tx_count !== CW'(tx_q.size())) begin errors++; $display("FAIL rand%0d_counts got rx %0d tx %0d want %0d %0d", it, rx_count, tx_count, rx_q.size(), tx_q.size()); end
            checks++; if (parity !== parity_m) begin errors++; $display("FAIL rand%0d_parity got %b want %b", it, parity, parity_m); end
        end
    endtask

    initial begin
        msg.out_rdy = 1'b0;
        msg.in_val  = 1'b0;
        msg.in_msg  = '0;
        wait_clk(2);
        test_reset();
        test_rx_basic();
        test_tx_path();
        test_rx_full();
        test_aborted();
        test_loopthrough();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_minion_fifo_adapter.md
# spi_minion_fifo_adapter

Parametrised SPI minion with flow-controlled, FIFO-buffered message ports toward the user design. It is the next-generation core-side SPI block behind the user project wrapper GPIO pins and is generalised in payload width and FIFO depth. It adds per-transaction credit flow control, occupancy counters, a registered parity output and an internal loopthrough mode. All SPI pins are oversampled in the single `clk` domain.

## Interface

- `NBITS`, 32, payload bits per message; SPI packet width is P = NBITS+2
- `DEPTH`, 4, entries in each of the RX and TX FIFOs; power of 2, ≥2
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `spi_cs`  in  1  chip select, active-low, asynchronous to `clk`
- `spi_sclk`  in  1  SPI clock, mode 0, asynchronous to `clk`
- `spi_mosi`  in  1  serial data in
- `spi_miso`  out  1  serial data out, MSB first
- `loopthrough_sel`  in  1  1 routes RX FIFO output into TX FIFO input
- `out_msg`  out  NBITS  head of RX FIFO (message toward design)
- `out_val` / `out_rdy`  out / in  1  RX dequeue handshake
- `in_msg`  in  NBITS  message from design
- `in_val` / `in_rdy`  in / out  1  TX enqueue handshake
- `rx_count`, `tx_count`  out  $clog2(DEPTH+1)  FIFO occupancies
- `parity`  out  1  XOR-reduction of the last payload pushed into RX

## Operation

- `spi_cs`, `spi_sclk` and `spi_mosi` each pass through 2-flop synchronizers; a third flop on cs/sclk supplies edge detection. All SPI actions use the synchronized versions.
- **State machine.** IDLE → (cs fall) → XFER → (cs rise) → IDLE.
- **cs fall.** Load the shift register with {tx_val, rx_space, tx_head}:
  - tx_val = TX nonempty;
  - rx_space = RX not full;
  - tx_head = TX head, or 0 if TX is empty.
  - Latch tx_val and rx_space for the whole transaction and clear the bit counter.
- **sclk rise (XFER).** Capture mosi into the sample bit and increment the bit counter, saturating at P+1.
- **sclk fall (XFER).** Shift the register left, inserting the sample bit. `spi_miso` = register MSB.
- **cs rise.** Form rx_pkt = {shreg[P-2:0], sample}, where rx_pkt[P-1] = m_val and rx_pkt[P-2] = m_space. If the bit counter == P:
  - if m_val and latched rx_space, push rx_pkt[NBITS-1:0] into RX and set parity to its XOR;
  - if m_space and latched tx_val, pop TX.
- **Aborted transaction.** If the bit counter ≠ P, nothing is pushed or popped.
- **FIFO port rules.**
  - `out_val` = RX nonempty; `in_rdy` = TX not full.
  - Dequeue occurs on `out_val & out_rdy`; enqueue occurs on `in_val & in_rdy`.
- **Loopthrough (`loopthrough_sel`=1).**
  - `out_val`=0 and `in_rdy`=0.
  - RX head moves to TX whenever RX is nonempty and TX is not full, one per cycle.
  - `in_msg`/`out_rdy` are ignored.
- **Simultaneous events.** A push and a pop on the same FIFO in the same cycle are both legal; occupancy is unchanged.
  - An SPI TX pop plus an `in` enqueue while TX is full cannot happen, because `in_rdy`=0.
  - An RX push cannot overflow, because space only grows during a transaction.
- **Reset (any time, including mid-transaction).**
  - Outputs: `spi_miso`=0, `out_val`=0, `in_rdy`=1, counts=0, `parity`=0.
  - Internal state: FIFOs empty, state IDLE, sync flops cleared to the idle levels (cs=1, sclk=0).
  - If `spi_cs` is already low when reset releases, that transaction is ignored until cs returns high.

## Timing

- Pin-to-action latency is 3 `clk` rising edges (2 sync + edge detect).
- `out_val` rises on the 3rd edge after the `spi_cs` pin rises (push).
- `rx_count`/`parity` update on the same edge as the push.
- `spi_miso` updates on the 3rd edge after an sclk pin fall, or after a cs pin fall for the first bit.
- SPI host requirements:
  - sclk high and low each ≥4 `clk` periods;
  - first sclk rise ≥4 `clk` after cs fall;
  - cs rise ≥4 `clk` after last sclk rise;
  - cs high ≥4 `clk` between transactions.
- FIFO handshakes have 1-cycle latency: an enqueue at edge k is visible as `out_val`/head at edge k+1. There is no combinational path from `out_rdy` to `out_val` or from `in_val` to `in_rdy`.

## Test plan

- **Reset, then idle.** Reset, then one 34-bit transaction (NBITS=32) with m_val=1, payload 0xDEADBEEF → miso first 2 bits = 0,1; `out_msg`=0xDEADBEEF with `out_val`=1 three edges after cs rise; `rx_count`=1; `parity`=0.
- **TX path.** Enqueue 0x12345678 via `in`, then a transaction with m_space=1 → miso packet = {1,1,0x12345678}; `tx_count` 1→0 after cs rise. Repeat with m_space=0 → the same word is resent next transaction.
- **RX full (DEPTH=4).** Push 4 words with `out_rdy`=0, then a 5th transaction → miso bit P-2 = 0; 5th payload dropped; `rx_count` stays 4; parity unchanged.
- **Aborted transaction.** Raise cs after 20 sclk pulses → no push/pop; the next full transaction works normally.
- **Loopthrough.** `loopthrough_sel`=1; send 0xA5A5A5A5 → the next transaction's miso payload is 0xA5A5A5A5 with tx_val=1; `out_val` stays 0.
- **Reset mid-transaction.** Assert reset after 10 sclk pulses while cs is low and release it with cs still low → finishing that transaction pushes nothing; the next transaction succeeds.
